out_port_arbiter: RTL and testbench
===================================

OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

Interface
REQ-001 The block SHALL have parameter LINK_WIDTH, default 35, the flit width; bit LINK_WIDTH-1 = VLD, LINK_WIDTH-2 = SOP, LINK_WIDTH-3 = EOP.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, the watchdog limit in cycles (used only under REQ-024).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  req[i]=1: input port i's sel bit targets this output port.
REQ-006 in_data0..in_data3  input  LINK_WIDTH each  flit presented by input port i.
REQ-007 out_ready  input  1  downstream accepts a flit at the next edge.
REQ-008 grant  output  4  registered one-hot lock owner; all zero when idle.
REQ-009 pop  output  4  combinational one-hot transfer strobe; pop[i]=1 in the cycle a flit moves from input i.
REQ-010 out_data  output  LINK_WIDTH  registered output flit.
REQ-011 err_timeout  output  1  sticky watchdog flag.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-013 In IDLE with req!=0, the block SHALL select the first set req bit searching upward from rr_ptr modulo 4, and next cycle SHALL be in BUSY with grant one-hot at the winner.
REQ-014 In IDLE, pop SHALL be 0 and no flit SHALL transfer; arbitration costs exactly one cycle.
REQ-015 A transfer SHALL occur when state is BUSY, in_data[owner] VLD=1, and out_ready=1; pop[owner]=1 in that cycle only.
REQ-016 A flit transferred at edge T SHALL appear on out_data after edge T, i.e. latency one cycle.
REQ-017 In any cycle without a transfer, out_data SHALL load all zeros (VLD=0) at the next edge.
REQ-018 A transferred flit with EOP=1 (including single-flit SOP+EOP) SHALL return the FSM to IDLE, clear grant, and set rr_ptr to owner+1 modulo 4.
REQ-019 While BUSY, the lock SHALL be held regardless of req; deassertion of req[owner] mid-packet SHALL be ignored.
REQ-020 A flit with VLD=0 from the owner SHALL be a bubble: no transfer, lock held.
REQ-021 New requests arriving in the EOP transfer cycle SHALL be arbitrated only after IDLE is entered, giving one bubble cycle between packets.
REQ-022 rr_ptr SHALL be 2 bits and wrap from 3 to 0.

Reset
REQ-023 On reset low, asynchronously: state=IDLE, rr_ptr=0, grant=0, out_data=0, err_timeout=0, watchdog counter=0; pop SHALL be 0 while reset is low; a packet in flight is discarded with no recovery.

Configuration
REQ-024 With macro ARB_WATCHDOG_EN defined, a counter SHALL count consecutive BUSY cycles without a transfer; on reaching TIMEOUT it SHALL force IDLE, set rr_ptr=owner+1, and set err_timeout=1 until reset; any transfer SHALL clear the counter.
REQ-025 Without ARB_WATCHDOG_EN, no counter SHALL exist, err_timeout SHALL be tied 0, and the lock SHALL be held indefinitely until EOP.

Verification
REQ-026 After reset, req=4'b0101, rr_ptr=0 -> grant=4'b0001 one cycle later; a 3-flit packet from port 0 with out_ready=1 -> out_data shows the 3 flits on consecutive cycles; then grant=4'b0100.
REQ-027 req=4'b1111 held, 1-flit packets on all ports -> grant order 0,1,2,3,0 with one idle cycle between packets.
REQ-028 Owner 2 BUSY, out_ready=0 for 5 cycles -> pop=0, out_data VLD=0, grant stays 4'b0100; out_ready=1 -> transfer resumes.
REQ-029 req[owner] dropped mid-packet while req[3]=1 -> grant unchanged until EOP transfers, then IDLE, then grant=4'b1000.
REQ-030 ARB_WATCHDOG_EN, TIMEOUT=16, owner sends VLD=0 for 16 cycles -> IDLE, err_timeout=1 and sticky; without macro -> still BUSY, err_timeout=0.
REQ-031 reset low mid-packet -> all outputs zero immediately, no clock edge needed; first arbitration after release starts from port 0.

Source files
------------

// File: rtl/out_port_arbiter.sv
// Four-input round-robin output port arbiter: locks one input for a whole packet and forwards its flits.
// Optional watchdog that breaks a stalled lock is enabled by defining ARB_WATCHDOG_EN.
module out_port_arbiter #(
  parameter int LINK_WIDTH = 35,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [LINK_WIDTH-1:0] in_data0,
  input  logic [LINK_WIDTH-1:0] in_data1,
  input  logic [LINK_WIDTH-1:0] in_data2,
  input  logic [LINK_WIDTH-1:0] in_data3,
  input  logic                  out_ready,
  output logic [3:0]            grant,
  output logic [3:0]            pop,
  output logic [LINK_WIDTH-1:0] out_data,
  output logic                  err_timeout
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;
  localparam int   VLD     = LINK_WIDTH - 1;
  localparam int   EOP     = LINK_WIDTH - 3;

  logic                  state_q, state_d;
  logic [1:0]            rr_q, rr_d;
  logic [1:0]            owner_q, owner_d;
  logic [3:0]            grant_q, grant_d;
  logic [LINK_WIDTH-1:0] out_data_q, out_data_d;
  logic [LINK_WIDTH-1:0] sel_data;
  logic [1:0]            win;
  logic                  win_found;
  logic                  xfer;
  logic                  wd_expire;

  always_comb begin
    case (owner_q)
      2'd0:    sel_data = in_data0;
      2'd1:    sel_data = in_data1;
      2'd2:    sel_data = in_data2;
      default: sel_data = in_data3;
    endcase
  end

  assign xfer = (state_q == ST_BUSY) && sel_data[VLD] && out_ready;

  // Round-robin search: first requester at or above rr_q, wrapping modulo 4.
  always_comb begin
    win       = rr_q;
    win_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && req[rr_q + 2'(k)]) begin
        win       = rr_q + 2'(k);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    out_data_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_BUSY;
          owner_d = win;
          grant_d = 4'b0001 << win;
        end
      end
      default: begin
        if (xfer) begin
          out_data_d = sel_data;
        end
        if ((xfer && sel_data[EOP]) || wd_expire) begin
          state_d = ST_IDLE;
          grant_d = 4'b0000;
          rr_d    = owner_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= 2'd0;
      owner_q    <= 2'd0;
      grant_q    <= 4'b0000;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      out_data_q <= out_data_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  // Counts consecutive lock-held cycles with no flit moving; the expiring cycle releases the lock.
  assign wd_expire = (state_q == ST_BUSY) && !xfer && (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    wd_d  = '0;
    err_d = err_q;
    if ((state_q == ST_BUSY) && !xfer) begin
      if (wd_expire) begin
        err_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic [31:0] wd_timeout_unused;

  assign wd_timeout_unused = 32'(TIMEOUT);
  assign wd_expire         = 1'b0;
  assign err_timeout       = 1'b0;
`endif

  assign grant    = grant_q;
  assign out_data = out_data_q;
  assign pop      = (xfer ? grant_q : 4'b0000) & {4{reset}};

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: vector table for the main packet flows plus hand sequences
// for the stalled-lock watchdog and asynchronous reset mid-packet.
module tb_out_port_arbiter;

  localparam int W = 35;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
  logic         out_ready;
  logic [3:0]   grant;
  logic [3:0]   pop;
  logic [W-1:0] out_data;
  logic         err_timeout;

  int checks;
  int failures;

  out_port_arbiter #(.LINK_WIDTH(W), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .in_data0   (in_data0),
    .in_data1   (in_data1),
    .in_data2   (in_data2),
    .in_data3   (in_data3),
    .out_ready  (out_ready),
    .grant      (grant),
    .pop        (pop),
    .out_data   (out_data),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic [3:0]   r;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] d3;
    logic         rdy;
    logic [3:0]   g;
    logic [3:0]   p;
    logic [W-1:0] o;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish within bound");
    $fatal(1, "bench timeout");
  end

  function automatic logic [W-1:0] flit(input logic v, input logic s, input logic e,
                                        input logic [31:0] pl);
    return {v, s, e, pl};
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [W-1:0] d0, input logic [W-1:0] d1,
                     input logic [W-1:0] d2, input logic [W-1:0] d3, input logic rdy,
                     input logic [3:0] g, input logic [3:0] p, input logic [W-1:0] o);
    vec_t v;
    v.r = r; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.rdy = rdy; v.g = g; v.p = p; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] r, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3, input logic rdy);
    req = r; in_data0 = d0; in_data1 = d1; in_data2 = d2; in_data3 = d3; out_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] z;
  logic [W-1:0] a1, a2, a3, b1, b2, b3, bub, c1, e1, f1;
  logic [W-1:0] dd[4];

  initial begin
    checks   = 0;
    failures = 0;
    z   = '0;
    a1  = flit(1, 1, 0, 32'hA1);
    a2  = flit(1, 0, 0, 32'hA2);
    a3  = flit(1, 0, 1, 32'hA3);
    b1  = flit(1, 1, 0, 32'hB1);
    b2  = flit(1, 0, 0, 32'hB2);
    b3  = flit(1, 0, 1, 32'hB3);
    bub = flit(0, 0, 0, 32'h0);
    c1  = flit(1, 1, 1, 32'hC1);
    e1  = flit(1, 1, 1, 32'hE1);
    f1  = flit(1, 1, 0, 32'hF1);
    for (int i = 0; i < 4; i++) dd[i] = flit(1, 1, 1, 32'hD0 + 32'(i));

    // 3-flit packet from port 0, then port 2 wins from rr_ptr=1
    add(4'b0101, z,  z, z,  z, 1, 4'b0000, 4'b0000, z);
    add(4'b0101, a1, z, z,  z, 1, 4'b0001, 4'b0001, z);
    add(4'b0101, a2, z, z,  z, 1, 4'b0001, 4'b0001, a1);
    add(4'b0101, a3, z, z,  z, 1, 4'b0001, 4'b0001, a2);
    add(4'b0100, z,  z, b1, z, 1, 4'b0000, 4'b0000, a3);
    // downstream stall for 5 cycles, then resume
    for (int i = 0; i < 5; i++) add(4'b0100, z, z, b1, z, 0, 4'b0100, 4'b0000, z);
    add(4'b0100, z, z, b1,  z,  1, 4'b0100, 4'b0100, z);
    // req[owner] dropped and req[3] raised mid-packet, plus a bubble from the owner
    add(4'b1000, z, z, b2,  c1, 1, 4'b0100, 4'b0100, b1);
    add(4'b1000, z, z, bub, c1, 1, 4'b0100, 4'b0000, b2);
    add(4'b1000, z, z, b3,  c1, 1, 4'b0100, 4'b0100, z);
    add(4'b1000, z, z, z,   c1, 1, 4'b0000, 4'b0000, b3);
    add(4'b1000, z, z, z,   c1, 1, 4'b1000, 4'b1000, z);
    // all ports requesting single-flit packets: order 0,1,2,3,0 with idle cycles between
    add(4'b1111, dd[0], dd[1], dd[2], dd[3], 1, 4'b0000, 4'b0000, c1);
    add(4'b1111, dd[0], dd[1], dd[2], dd[3], 1, 4'b0001, 4'b0001, z);
    add(4'b1111, dd[0], dd[1], dd[2], dd[3], 1, 4'b0000, 4'b0000, dd[0]);
    add(4'b1111, dd[0], dd[1], dd[2], dd[3], 1, 4'b0010, 4'b0010, z);
    add(4'b1111, dd[0], dd[1], dd[2], dd[3], 1, 4'b0000, 4'b0000, dd[1]);
    add(4'b1111, dd[0], dd[1], dd[2], dd[3], 1, 4'b0100, 4'b0100, z);
    add(4'b1111, dd[0], dd[1], dd[2], dd[3], 1, 4'b0000, 4'b0000, dd[2]);
    add(4'b1111, dd[0], dd[1], dd[2], dd[3], 1, 4'b1000, 4'b1000, z);
    add(4'b1111, dd[0], dd[1], dd[2], dd[3], 1, 4'b0000, 4'b0000, dd[3]);
    add(4'b1111, dd[0], dd[1], dd[2], dd[3], 1, 4'b0001, 4'b0001, z);
    add(4'b0000, z, z, z, z, 1, 4'b0000, 4'b0000, dd[0]);
    add(4'b0000, z, z, z, z, 1, 4'b0000, 4'b0000, z);

    reset = 1'b0;
    drive(4'b0000, z, z, z, z, 1'b1);
    #2;
    chk("reset_grant", 0, 64'(grant), 64'(4'b0000));
    chk("reset_pop", 0, 64'(pop), 64'(4'b0000));
    chk("reset_out_data", 0, 64'(out_data), 64'(z));
    chk("reset_err", 0, 64'(err_timeout), 64'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].rdy);
      #1;
      chk("vec_grant", i, 64'(grant), 64'(vecs[i].g));
      chk("vec_pop", i, 64'(pop), 64'(vecs[i].p));
      chk("vec_out_data", i, 64'(out_data), 64'(vecs[i].o));
      next_cycle();
    end

    // Stalled lock: port 1 wins, then only bubbles for 16 cycles with req removed
    drive(4'b0010, z, z, z, z, 1'b1);
    #1;
    chk("wd_arb_grant", 0, 64'(grant), 64'(4'b0000));
    next_cycle();
    drive(4'b0000, z, bub, z, z, 1'b1);
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("wd_hold_grant", k, 64'(grant), 64'(4'b0010));
      chk("wd_hold_pop", k, 64'(pop), 64'(4'b0000));
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
`ifdef ARB_WATCHDOG_EN
      chk("wd_after_grant", k, 64'(grant), 64'(4'b0000));
      chk("wd_after_err", k, 64'(err_timeout), 64'(1'b1));
`else
      chk("wd_after_grant", k, 64'(grant), 64'(4'b0010));
      chk("wd_after_err", k, 64'(err_timeout), 64'(1'b0));
`endif
      next_cycle();
    end
    drive(4'b0000, z, e1, z, z, 1'b1);
    #1;
`ifdef ARB_WATCHDOG_EN
    chk("wd_final_pop", 0, 64'(pop), 64'(4'b0000));
`else
    chk("wd_final_pop", 0, 64'(pop), 64'(4'b0010));
`endif
    next_cycle();
    drive(4'b0000, z, z, z, z, 1'b1);
`ifdef ARB_WATCHDOG_EN
    chk("wd_final_out", 0, 64'(out_data), 64'(z));
`else
    chk("wd_final_out", 0, 64'(out_data), 64'(e1));
`endif
    next_cycle();
    chk("wd_final_idle", 0, 64'(grant), 64'(4'b0000));

    // Asynchronous reset in the middle of a packet from port 3
    drive(4'b1000, z, z, z, f1, 1'b1);
    next_cycle();
    #1;
    chk("rst_pre_pop", 0, 64'(pop), 64'(4'b1000));
    next_cycle();
    chk("rst_pre_out", 0, 64'(out_data), 64'(f1));
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_grant", 0, 64'(grant), 64'(4'b0000));
    chk("rst_async_pop", 0, 64'(pop), 64'(4'b0000));
    chk("rst_async_out", 0, 64'(out_data), 64'(z));
    chk("rst_async_err", 0, 64'(err_timeout), 64'(1'b0));
    next_cycle();
    reset = 1'b1;
    drive(4'b1111, z, z, z, z, 1'b1);
    #1;
    chk("rst_release_idle", 0, 64'(grant), 64'(4'b0000));
    next_cycle();
    chk("rst_first_arb", 0, 64'(grant), 64'(4'b0001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
